ws2812_frame_ctrl: RTL and testbench

Frame sequencer for the ws2812_driver bit encoder.
- Accepts a frame trigger and a stream of 24-bit GRB pixels.
- Serialises each pixel MSB-first into single-bit code transfers on the driver's code_in/code_in_valid/ready_out handshake.
- After LED_NUM pixels, holds the line idle for the WS2812 latch/reset period, then reports frame completion.
- Sits between the pixel source (frame buffer/pattern generator) and ws2812_driver.

---
 rtl/ws2812_pkg.sv | 21 ++
 rtl/ws2812_frame_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ws2812_frame_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared types and constants for the ws2812 frame sequencer
//
// Purpose : FSM state encoding, pixel width and the GRB pixel type used by
//           ws2812_frame_ctrl.
// Ports   : none (package)

package ws2812_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    HOLD,
    LATCH
  } state_t;

  localparam int PIXEL_W = 24;

  typedef logic [PIXEL_W-1:0] grb_t;

endpackage

// File: rtl/ws2812_frame_ctrl.sv
// rtl/ws2812_frame_ctrl.sv - frame sequencer feeding single-bit codes to ws2812_driver
//
// Purpose : On a frame request, pulls LED_NUM GRB pixels from the pixel source,
//           serialises each MSB-first as one-cycle bit strobes to the driver,
//           then holds the line idle for RESET_CYCLES and pulses frame_done_out.
// Ports   :
//   clk_in, rst_n_in                 clock, asynchronous active-low reset
//   frame_start_in                   one-cycle frame request (honoured in IDLE only)
//   busy_out, frame_done_out         frame in progress / one-cycle completion pulse
//   pixel_in, pixel_in_valid/_ready  GRB pixel stream from the pixel source
//   code_out, code_out_valid         bit and bit strobe to the driver
//   driver_ready_in                  driver idle indication
//   underrun_out                     sticky: pixel source stalled too long this frame

module ws2812_frame_ctrl
  import ws2812_pkg::*;
#(
  parameter int LED_NUM      = 8,
  parameter int RESET_CYCLES = 15000,
  parameter int STALL_LIMIT  = 1000
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               frame_start_in,
  output logic               busy_out,
  output logic               frame_done_out,
  input  logic [PIXEL_W-1:0] pixel_in,
  input  logic               pixel_in_valid,
  output logic               pixel_in_ready,
  output logic               code_out,
  output logic               code_out_valid,
  input  logic               driver_ready_in,
  output logic               underrun_out
);

  localparam int PIX_W   = $clog2(LED_NUM + 1);
  localparam int LATCH_W = $clog2(RESET_CYCLES + 1);
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);
  localparam int BIT_W   = $clog2(PIXEL_W + 1);

  localparam logic [PIX_W-1:0]   LAST_PIX   = PIX_W'(LED_NUM - 1);
  localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(RESET_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(STALL_LIMIT);
  localparam logic [STALL_W-1:0] STALL_PRE  = STALL_W'(STALL_LIMIT - 1);
  localparam logic [BIT_W-1:0]   BIT_TOP    = BIT_W'(PIXEL_W - 1);

  state_t             state_q, state_d;
  grb_t               shift_q, shift_d;
  logic [BIT_W-1:0]   bit_idx_q, bit_idx_d;
  logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [LATCH_W-1:0] latch_q, latch_d;
  logic               busy_q, busy_d;
  logic               underrun_q, underrun_d;
  logic               code_q, code_d;
  logic               code_valid_q, code_valid_d;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      pix_cnt_q    <= '0;
      stall_q      <= '0;
      latch_q      <= '0;
      busy_q       <= 1'b0;
      underrun_q   <= 1'b0;
      code_q       <= 1'b0;
      code_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      pix_cnt_q    <= pix_cnt_d;
      stall_q      <= stall_d;
      latch_q      <= latch_d;
      busy_q       <= busy_d;
      underrun_q   <= underrun_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    bit_idx_d      = bit_idx_q;
    pix_cnt_d      = pix_cnt_q;
    stall_d        = stall_q;
    latch_d        = latch_q;
    busy_d         = busy_q;
    underrun_d     = underrun_q;
    code_d         = code_q;
    code_valid_d   = 1'b0;
    pixel_in_ready = 1'b0;
    frame_done_out = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (frame_start_in) begin
          state_d    = LOAD;
          busy_d     = 1'b1;
          underrun_d = 1'b0;
          pix_cnt_d  = '0;
          stall_d    = '0;
        end
      end

      LOAD: begin
        pixel_in_ready = 1'b1;
        if (pixel_in_valid) begin
          shift_d   = pixel_in;
          bit_idx_d = BIT_TOP;
          stall_d   = '0;
          state_d   = SEND;
        end else begin
          // Saturating stall count; underrun flags on the cycle it reaches the limit.
          if (stall_q != STALL_MAX) begin
            stall_d = stall_q + STALL_W'(1);
          end
          if (stall_q >= STALL_PRE) begin
            underrun_d = 1'b1;
          end
        end
      end

      SEND: begin
        if (driver_ready_in) begin
          code_valid_d = 1'b1;
          code_d       = shift_q[PIXEL_W-1];
          state_d      = HOLD;
        end
      end

      // One dead cycle while the driver drops ready in response to the strobe.
      HOLD: begin
        shift_d = shift_q << 1;
        if (bit_idx_q != '0) begin
          bit_idx_d = bit_idx_q - BIT_W'(1);
          state_d   = SEND;
        end else if (pix_cnt_q != LAST_PIX) begin
          pix_cnt_d = pix_cnt_q + PIX_W'(1);
          state_d   = LOAD;
        end else begin
          latch_d = '0;
          state_d = LATCH;
        end
      end

      // Counting starts on the first cycle the driver reports idle after the last bit.
      LATCH: begin
        if (latch_q == LATCH_LAST) begin
          frame_done_out = 1'b1;
          busy_d         = 1'b0;
          latch_d        = '0;
          state_d        = IDLE;
        end else if ((latch_q != '0) || driver_ready_in) begin
          latch_d = latch_q + LATCH_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy_out       = busy_q;
  assign underrun_out   = underrun_q;
  assign code_out       = code_q;
  assign code_out_valid = code_valid_q;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// tb/tb_ws2812_frame_ctrl.sv - self-checking bench for ws2812_frame_ctrl

module tb_ws2812_frame_ctrl;

  localparam int LED_NUM      = 2;
  localparam int RESET_CYCLES = 20;
  localparam int STALL_LIMIT  = 8;
  localparam int FRAME_BITS   = LED_NUM * 24;
  localparam int WAIT_LIMIT   = 5000;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b1;
  logic        frame_start_in = 1'b0;
  logic [23:0] pixel_in = '0;
  logic        pixel_in_valid = 1'b0;
  logic        driver_ready_in;
  logic        busy_out, frame_done_out, pixel_in_ready;
  logic        code_out, code_out_valid, underrun_out;

  ws2812_frame_ctrl #(
    .LED_NUM     (LED_NUM),
    .RESET_CYCLES(RESET_CYCLES),
    .STALL_LIMIT (STALL_LIMIT)
  ) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .frame_start_in (frame_start_in),
    .busy_out       (busy_out),
    .frame_done_out (frame_done_out),
    .pixel_in       (pixel_in),
    .pixel_in_valid (pixel_in_valid),
    .pixel_in_ready (pixel_in_ready),
    .code_out       (code_out),
    .code_out_valid (code_out_valid),
    .driver_ready_in(driver_ready_in),
    .underrun_out   (underrun_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pixel source: each entry is held invalid for 'gap' cycles of the controller asking for it.
  typedef struct {
    logic [23:0] pix;
    int          gap;
  } feed_t;
  feed_t feed_q[$];
  feed_t f;

  // Driver stand-in: bit 0 busy 3 cycles, bit 1 busy 9 cycles (high+low times).
  logic drv_ready = 1'b1;
  int   drv_cnt   = 0;
  logic force_low = 1'b0;
  assign driver_ready_in = drv_ready && !force_low;

  // What happened at each active edge, as seen by the controller.
  logic s_start = 1'b0, s_acc = 1'b0, s_stall = 1'b0, s_drdy = 1'b0;
  always @(posedge clk_in) begin
    s_start <= frame_start_in;
    s_acc   <= pixel_in_valid && pixel_in_ready;
    s_stall <= pixel_in_ready && !pixel_in_valid;
    s_drdy  <= driver_ready_in;
  end

  // Frame-level model: expected bit stream, busy window, latch timing, underrun.
  bit   exp_q[$];
  bit   got_q[$];
  logic exp_busy = 1'b0, exp_under = 1'b0, exp_code = 1'b0, exp_done;
  logic latch_arm = 1'b0, in_latch = 1'b0, done_prev = 1'b0, idle_prev;
  int   latch_rdy = 0, stall_run = 0, frame_strobes = 0, frame_pixels = 0;
  int   cyc = 0, total_strobes = 0, done_count = 0, cyc_rise = -1, cyc_done = -1;

  always @(negedge clk_in) begin
    cyc++;
    if (!rst_n_in) begin
      exp_busy = 1'b0; exp_under = 1'b0; exp_code = 1'b0;
      latch_arm = 1'b0; in_latch = 1'b0; done_prev = 1'b0;
      latch_rdy = 0; stall_run = 0; frame_strobes = 0; frame_pixels = 0;
      exp_q.delete(); feed_q.delete();
      drv_ready = 1'b1; drv_cnt = 0; pixel_in_valid = 1'b0;
    end else begin
      idle_prev = !exp_busy;
      if (done_prev) exp_busy = 1'b0;
      done_prev = 1'b0;
      if (s_start && idle_prev) begin
        exp_busy = 1'b1; exp_under = 1'b0; stall_run = 0;
        frame_strobes = 0; frame_pixels = 0;
        in_latch = 1'b0; latch_arm = 1'b0; latch_rdy = 0;
        got_q.delete();
      end
      if (in_latch && s_drdy) latch_rdy++;
      if (latch_arm) begin in_latch = 1'b1; latch_arm = 1'b0; end
      if (s_acc) begin
        if (feed_q.size() > 0) begin
          f = feed_q.pop_front();
          for (int i = 23; i >= 0; i--) exp_q.push_back(f.pix[i]);
        end
        frame_pixels++;
        stall_run = 0;
      end else if (s_stall) begin
        stall_run++;
        if (stall_run >= STALL_LIMIT) exp_under = 1'b1;
        if (feed_q.size() > 0 && feed_q[0].gap > 0) begin
          f = feed_q[0]; f.gap--; feed_q[0] = f;
        end
      end

      exp_done = in_latch && (latch_rdy == RESET_CYCLES - 1);
      check("busy_out", busy_out, exp_busy);
      check("frame_done_out", frame_done_out, exp_done);
      check("underrun_out", underrun_out, exp_under);
      if (!exp_busy) check("pixel_in_ready idle", pixel_in_ready, 1'b0);
      if (code_out_valid) begin
        check("strobe needs driver ready", s_drdy, 1'b1);
        check("strobe inside frame", exp_busy, 1'b1);
        if (exp_q.size() == 0) begin
          check("unexpected strobe", frame_strobes, FRAME_BITS);
        end else begin
          check("code_out bit", code_out, exp_q[0]);
          void'(exp_q.pop_front());
        end
        exp_code = code_out;
        got_q.push_back(code_out);
        frame_strobes++;
        total_strobes++;
        if (frame_strobes == FRAME_BITS) latch_arm = 1'b1;
      end else begin
        check("code_out held", code_out, exp_code);
      end
      if (exp_done) begin
        check("bits per frame", frame_strobes, FRAME_BITS);
        check("pixels per frame", frame_pixels, LED_NUM);
        check("bits left over", exp_q.size(), 0);
        done_prev = 1'b1;
        done_count++;
        cyc_done = cyc;
      end

      if (code_out_valid) begin
        drv_ready = 1'b0;
        drv_cnt   = code_out ? 9 : 3;
      end else if (drv_cnt > 0) begin
        drv_cnt--;
        if (drv_cnt == 0) begin
          drv_ready = 1'b1;
          if (frame_strobes == FRAME_BITS) cyc_rise = cyc;
        end
      end

      if (feed_q.size() > 0 && feed_q[0].gap == 0) begin
        pixel_in_valid = 1'b1;
        pixel_in       = feed_q[0].pix;
      end else begin
        pixel_in_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  task automatic start_pulse();
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
  endtask

  task automatic push_frame(input logic [23:0] p0, input logic [23:0] p1, input int gap1);
    feed_t e;
    e.pix = p0; e.gap = 0;    feed_q.push_back(e);
    e.pix = p1; e.gap = gap1; feed_q.push_back(e);
  endtask

  task automatic timeout(input string name, input int seen, input int want);
    n_checks++;
    n_fail++;
    $display("FAIL %s timeout: got %0d expected %0d", name, seen, want);
  endtask

  task automatic wait_strobes(input int n);
    int k = 0;
    while (frame_strobes < n && k < WAIT_LIMIT) begin tick(); k++; end
    if (k >= WAIT_LIMIT) timeout("wait_strobes", frame_strobes, n);
  endtask

  task automatic wait_done();
    int k = 0;
    while (frame_done_out !== 1'b1 && k < WAIT_LIMIT) begin tick(); k++; end
    if (k >= WAIT_LIMIT) timeout("wait_done", done_count, done_count + 1);
  endtask

  task automatic check_frame_bits(input string name, input logic [47:0] want);
    logic [47:0] w = '0;
    foreach (got_q[i]) w = {w[46:0], got_q[i]};
    check({name, " bit count"}, got_q.size(), FRAME_BITS);
    check({name, " bits"}, w, want);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, " busy_out"}, busy_out, 1'b0);
    check({name, " frame_done_out"}, frame_done_out, 1'b0);
    check({name, " pixel_in_ready"}, pixel_in_ready, 1'b0);
    check({name, " code_out"}, code_out, 1'b0);
    check({name, " code_out_valid"}, code_out_valid, 1'b0);
    check({name, " underrun_out"}, underrun_out, 1'b0);
  endtask

  initial begin
    #1 rst_n_in = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n_in = 1'b1;
    tick();
    check_outputs_zero("post-reset");

    // Frame 1: both pixels already valid; pin first-transaction latency and latch timing.
    push_frame(24'hA50F81, 24'h000001, 0);
    tick();
    start_pulse();
    check("first LOAD ready", pixel_in_ready, 1'b1);
    tick();
    check("SEND ready low", pixel_in_ready, 1'b0);
    tick();
    check("first strobe", code_out_valid, 1'b1);
    check("first bit", code_out, 1'b1);
    wait_done();
    check("latch gap", cyc_done - cyc_rise, RESET_CYCLES - 1);
    check("frame1 done count", done_count, 1);
    check_frame_bits("frame1", 48'hA50F81_000001);
    tick();
    check("busy falls", busy_out, 1'b0);

    // Frame 2: source stalls 12 cycles before pixel 2.
    push_frame(24'h123456, 24'h8000FF, 12);
    tick();
    start_pulse();
    begin
      int t0, t1, k;
      wait_strobes(24);
      k = 0;
      while (pixel_in_ready !== 1'b1 && k < WAIT_LIMIT) begin tick(); k++; end
      t0 = cyc;
      k = 0;
      while (underrun_out !== 1'b1 && k < WAIT_LIMIT) begin tick(); k++; end
      t1 = cyc;
      check("underrun delay", t1 - t0, STALL_LIMIT);
    end
    wait_done();
    check("underrun at done", underrun_out, 1'b1);
    check_frame_bits("frame2", 48'h123456_8000FF);
    tick();

    // Frame 3: stray starts during SEND and on the done cycle.
    push_frame(24'hFF0000, 24'h00FF00, 0);
    tick();
    start_pulse();
    check("underrun cleared", underrun_out, 1'b0);
    wait_strobes(3);
    start_pulse();
    wait_done();
    begin
      int s0, d0;
      s0 = total_strobes;
      d0 = done_count;
      start_pulse();
      repeat (40) tick();
      check("no extra strobes", total_strobes, s0);
      check("no extra done", done_count, d0);
      check("stays idle", busy_out, 1'b0);
    end
    check_frame_bits("frame3", 48'hFF0000_00FF00);

    // Frame 4: reset at bit 10, then a clean frame.
    push_frame(24'hC33C5A, 24'h0FF0AA, 0);
    tick();
    start_pulse();
    wait_strobes(10);
    #2 rst_n_in = 1'b0;
    #1 check_outputs_zero("async reset");
    repeat (3) tick();
    rst_n_in = 1'b1;
    tick();
    push_frame(24'h9669F0, 24'h01807E, 0);
    tick();
    start_pulse();
    wait_done();
    check_frame_bits("after reset", 48'h9669F0_01807E);
    tick();

    // Frame 5: driver ready held low for 30 cycles in SEND.
    push_frame(24'hF0F0F0, 24'h335577, 0);
    tick();
    start_pulse();
    wait_strobes(5);
    begin
      int s0;
      force_low = 1'b1;
      s0 = total_strobes;
      repeat (30) tick();
      check("no strobe while not ready", total_strobes, s0);
      force_low = 1'b0;
      repeat (3) tick();
      check("one strobe after ready", total_strobes, s0 + 1);
    end
    wait_done();
    check_frame_bits("ready stall", 48'hF0F0F0_335577);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
